uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter DATA_BITS, default 8: number of data bits per frame, legal range 5..8.
REQ-002 Parameter PARITY_EN, default 0: 1 means a parity bit follows the data bits.
REQ-003 Parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd parity; ignored when PARITY_EN=0.
REQ-004 Port clk, input, 1: single system clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1: synchronous, active-high reset.
REQ-006 Port tick, input, 1: 16x-baud enable strobe from the baud generator, one clk wide.
REQ-007 Port rx, input, 1: asynchronous serial line; idle level is high.
REQ-008 Port rx_data, output, 8: received data, LSB-aligned; unused upper bits are 0.
REQ-009 Port rx_valid, output, 1: one-clk pulse marking a completed frame.
REQ-010 Port frame_err, output, 1: stop bit sampled low; valid with rx_valid.
REQ-011 Port parity_err, output, 1: parity mismatch; valid with rx_valid; always 0 when PARITY_EN=0.
REQ-012 Port rx_busy, output, 1: high in every state except IDLE.

Function
REQ-013 rx shall pass through a 2-flop synchronizer, reset to 1, giving rx_s; all decisions use rx_s only.
REQ-014 The FSM shall have the states IDLE, START, DATA, PARITY and STOP; the tick counter (4-bit) and bit counter advance only on clk edges where tick=1.
REQ-015 IDLE: on a tick with rx_s=0, go to START and clear the tick counter; otherwise stay in IDLE.
REQ-016 START: on each tick, increment the tick counter; at the tick where the counter equals 7 (mid start bit):
  - rx_s=0: go to DATA and clear the tick counter and bit counter.
  - rx_s=1: false start; return to IDLE with no rx_valid.
REQ-017 DATA: at the tick where the counter equals 15:
  - shift rx_s in LSB-first and clear the tick counter;
  - after bit DATA_BITS-1, go to PARITY if PARITY_EN, else to STOP.
REQ-018 PARITY: at the counter=15 tick, capture rx_s and compute parity_err = XOR(data bits, parity bit) XOR PARITY_ODD; then go to STOP.
REQ-019 STOP: at the counter=15 tick:
  - load rx_data;
  - set frame_err = ~rx_s;
  - assert rx_valid for exactly one clk;
  - go to IDLE.
REQ-020 rx_data, frame_err and parity_err shall hold their values until the next rx_valid.
REQ-021 A line held low (break) shall produce one frame with rx_data=0 and frame_err=1; the FSM shall then stay in IDLE until rx_s is high for at least one tick, so a break yields no repeated frames.
REQ-022 When tick=0 the FSM and counters shall hold their values, whatever the state of rx.
REQ-023 Frame latency: rx_valid is asserted on the clk edge of the stop-bit centre tick, i.e. (8 + 16*(DATA_BITS + PARITY_EN + 1)) ticks after the first tick with rx_s low.
REQ-024 The tick counter shall wrap from 15 to 0 naturally; no other counter value is reachable outside the documented compare points.

Reset
REQ-025 While reset=1 at a clk edge:
  - the state goes to IDLE;
  - counters go to 0;
  - the shift register and rx_data go to 0;
  - rx_valid, frame_err, parity_err and rx_busy go to 0;
  - the synchronizer flops go to 1.
REQ-026 Reset asserted mid-frame shall abort the frame with no rx_valid; reception restarts on the next falling edge after reset is released.

Verification
REQ-027 Tick every 4 clk, DATA_BITS=8, no parity, send 0xA5 with stop=1 -> one rx_valid pulse, rx_data=0xA5, frame_err=0, parity_err=0; rx_valid arrives 152 ticks after the start edge.
REQ-028 Glitch: drive rx low for 5 ticks and then high -> no rx_valid, rx_busy returns to 0, FSM back in IDLE.
REQ-029 Send 0x3C with stop bit=0 -> rx_valid with rx_data=0x3C and frame_err=1; hold rx low for 40 more ticks -> no second rx_valid.
REQ-030 PARITY_EN=1, PARITY_ODD=0: send 0x07 with parity bit 1 -> parity_err=0; resend with parity bit 0 -> parity_err=1.
REQ-031 Assert reset during data bit 3 of a frame -> no rx_valid and all outputs 0; after release, send 0x5A -> rx_data=0x5A.
REQ-032 Back-to-back frames 0x00 then 0xFF, with no idle gap beyond the stop bit -> two rx_valid pulses, in that order, with the correct data.

Source files
------------

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 16x-oversampling UART receiver. Synchronises the serial line,
//             centres on the start bit, samples each data/parity/stop bit in
//             the middle of its cell and reports the frame with a one-clk
//             rx_valid pulse. A held-low line (break) produces one frame only.
//  Ports    : clk        - system clock (rising edge)
//             reset      - synchronous active-high reset
//             tick       - 16x baud enable strobe, one clk wide
//             rx         - asynchronous serial input, idle high
//             rx_data    - received data, LSB-aligned, upper bits 0
//             rx_valid   - one-clk pulse per completed frame
//             frame_err  - stop bit sampled low (valid with rx_valid)
//             parity_err - parity mismatch (valid with rx_valid)
//             rx_busy    - receiver is not idle
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       parity_err,
  output logic       rx_busy
);

  localparam logic [2:0] c_last_bit = 3'(DATA_BITS - 1);
  localparam logic       c_par_en   = (PARITY_EN != 0);
  localparam logic       c_par_odd  = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t      state_q,      state_d;
  logic        rx_meta_q,    rx_meta_d;
  logic        rx_s_q,       rx_s_d;
  logic [3:0]  tick_cnt_q,   tick_cnt_d;
  logic [2:0]  bit_cnt_q,    bit_cnt_d;
  logic [7:0]  shift_q,      shift_d;
  logic        par_pend_q,   par_pend_d;
  logic        break_wait_q, break_wait_d;
  logic [7:0]  rx_data_q,    rx_data_d;
  logic        rx_valid_q,   rx_valid_d;
  logic        frame_err_q,  frame_err_d;
  logic        parity_err_q, parity_err_d;
  logic        rx_busy_q,    rx_busy_d;

  always_comb begin
    rx_meta_d    = rx;
    rx_s_d       = rx_meta_q;
    state_d      = state_q;
    tick_cnt_d   = tick_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    par_pend_d   = par_pend_q;
    break_wait_d = break_wait_q;
    rx_data_d    = rx_data_q;
    frame_err_d  = frame_err_q;
    parity_err_d = parity_err_q;
    rx_valid_d   = 1'b0;

    if (tick) begin
      case (state_q)
        S_IDLE: begin
          // After a frame that ended with a low stop bit, the line must be
          // seen high once before a new start bit is accepted.
          if (rx_s_q) begin
            break_wait_d = 1'b0;
          end else if (!break_wait_q) begin
            state_d    = S_START;
            tick_cnt_d = 4'd0;
          end
        end
        S_START: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd7) begin
            if (!rx_s_q) begin
              state_d    = S_DATA;
              tick_cnt_d = 4'd0;
              bit_cnt_d  = 3'd0;
              shift_d    = 8'd0;
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_DATA: begin
          // Counter wraps 15 -> 0 on its own, which is the required clear.
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            // LSB-first: new bit enters at the top of the active field and
            // walks down, so bit 0 ends up at position 0.
            shift_d                = shift_q >> 1;
            shift_d[DATA_BITS - 1] = rx_s_q;
            bit_cnt_d              = bit_cnt_q + 3'd1;
            if (bit_cnt_q == c_last_bit) begin
              bit_cnt_d = 3'd0;
              state_d   = c_par_en ? S_PARITY : S_STOP;
            end
          end
        end
        S_PARITY: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            par_pend_d = (^shift_q) ^ rx_s_q ^ c_par_odd;
            state_d    = S_STOP;
          end
        end
        S_STOP: begin
          tick_cnt_d = tick_cnt_q + 4'd1;
          if (tick_cnt_q == 4'd15) begin
            rx_data_d    = shift_q;
            frame_err_d  = ~rx_s_q;
            parity_err_d = par_pend_q & c_par_en;
            rx_valid_d   = 1'b1;
            break_wait_d = ~rx_s_q;
            state_d      = S_IDLE;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    rx_busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      state_q      <= S_IDLE;
      tick_cnt_q   <= 4'd0;
      bit_cnt_q    <= 3'd0;
      shift_q      <= 8'd0;
      par_pend_q   <= 1'b0;
      break_wait_q <= 1'b0;
      rx_data_q    <= 8'd0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
      rx_busy_q    <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      par_pend_q   <= par_pend_d;
      break_wait_q <= break_wait_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
      rx_busy_q    <= rx_busy_d;
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
  assign rx_busy    = rx_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx. dut0 is 8N1, dut1 is 8E1.
//             A table of frames drives dut0, followed by hand-written
//             sequences for glitch, break, parity, and mid-frame reset.
//  Ports    : none
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic       rx0, rx1;
  logic [7:0] rx_data0, rx_data1;
  logic       rx_valid0, rx_valid1;
  logic       frame_err0, frame_err1;
  logic       parity_err0, parity_err1;
  logic       rx_busy0, rx_busy1;

  uart_rx #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx0),
    .rx_data(rx_data0), .rx_valid(rx_valid0), .frame_err(frame_err0),
    .parity_err(parity_err0), .rx_busy(rx_busy0)
  );

  uart_rx #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk(clk), .reset(reset), .tick(tick), .rx(rx1),
    .rx_data(rx_data1), .rx_valid(rx_valid1), .frame_err(frame_err1),
    .parity_err(parity_err1), .rx_busy(rx_busy1)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int tick_count = 0;

  int         vcnt0 = 0, vcnt1 = 0;
  int         vtick0 = 0, vtick1 = 0;
  logic [7:0] vdata0 = 8'd0, vdata1 = 8'd0;
  logic       vferr0 = 1'b0, vferr1 = 1'b0, vperr0 = 1'b0, vperr1 = 1'b0;

  // Record every rx_valid pulse together with the tick index it followed.
  always @(negedge clk) begin
    if (rx_valid0) begin
      vcnt0  <= vcnt0 + 1;
      vtick0 <= tick_count;
      vdata0 <= rx_data0;
      vferr0 <= frame_err0;
      vperr0 <= parity_err0;
    end
    if (rx_valid1) begin
      vcnt1  <= vcnt1 + 1;
      vtick1 <= tick_count;
      vdata1 <= rx_data1;
      vferr1 <= frame_err1;
      vperr1 <= parity_err1;
    end
  end

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  // One tick period = 4 clk, tick high for the first.
  task automatic tick1();
    tick_count++;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic hold(input int sel, input logic v, input int n);
    if (sel == 0) rx0 = v; else rx1 = v;
    repeat (n) tick1();
  endtask

  // start_tick is the index of the first tick of the start-bit cell; the
  // DUT first sees the low level one tick later (synchroniser delay).
  task automatic send_frame(input int sel, input logic [7:0] data,
                            input logic use_par, input logic par_bit,
                            input logic stop_bit, output int start_tick);
    start_tick = tick_count + 1;
    hold(sel, 1'b0, 16);
    for (int i = 0; i < 8; i++) hold(sel, data[i], 16);
    if (use_par) hold(sel, par_bit, 16);
    hold(sel, stop_bit, 16);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_data0"},  int'(rx_data0), 0);
    check({tag, "_valid0"}, int'(rx_valid0), 0);
    check({tag, "_ferr0"},  int'(frame_err0), 0);
    check({tag, "_perr0"},  int'(parity_err0), 0);
    check({tag, "_busy0"},  int'(rx_busy0), 0);
    check({tag, "_data1"},  int'(rx_data1), 0);
    check({tag, "_perr1"},  int'(parity_err1), 0);
    check({tag, "_busy1"},  int'(rx_busy1), 0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         idle;
    logic [7:0] exp_data;
    logic       exp_ferr;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int c, st;

    // 0x00 -> 0xFF back-to-back (idle 0 after the first).
    vecs[0] = '{8'hA5, 1'b1, 4, 8'hA5, 1'b0};
    vecs[1] = '{8'h00, 1'b1, 0, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 1'b1, 4, 8'hFF, 1'b0};
    vecs[3] = '{8'h81, 1'b1, 4, 8'h81, 1'b0};
    vecs[4] = '{8'hC3, 1'b0, 4, 8'hC3, 1'b1};
    vecs[5] = '{8'h01, 1'b1, 4, 8'h01, 1'b0};

    reset = 1'b1; tick = 1'b0; rx0 = 1'b1; rx1 = 1'b1;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("rst");
    hold(0, 1'b1, 4);

    // Table-driven frames on dut0: latency 8 + 16*9 = 152 ticks.
    for (int i = 0; i < 6; i++) begin
      c = vcnt0;
      send_frame(0, vecs[i].data, 1'b0, 1'b0, vecs[i].stop, st);
      hold(0, 1'b1, vecs[i].idle);
      check($sformatf("vec%0d_cnt", i),  vcnt0 - c, 1);
      check($sformatf("vec%0d_data", i), int'(vdata0), int'(vecs[i].exp_data));
      check($sformatf("vec%0d_ferr", i), int'(vferr0), int'(vecs[i].exp_ferr));
      check($sformatf("vec%0d_perr", i), int'(vperr0), 0);
      check($sformatf("vec%0d_lat", i),  vtick0 - (st + 1), 152);
    end

    // Glitch: 5 ticks low then high -> false start, no frame.
    c = vcnt0;
    hold(0, 1'b0, 3);
    check("glitch_busy_mid", int'(rx_busy0), 1);
    hold(0, 1'b0, 2);
    hold(0, 1'b1, 20);
    check("glitch_cnt", vcnt0 - c, 0);
    check("glitch_busy_end", int'(rx_busy0), 0);

    // Even parity on dut1: 0x07 has three ones, so parity bit 1 is correct.
    c = vcnt1;
    send_frame(1, 8'h07, 1'b1, 1'b1, 1'b1, st);
    hold(1, 1'b1, 4);
    check("par_ok_cnt", vcnt1 - c, 1);
    check("par_ok_data", int'(vdata1), 8'h07);
    check("par_ok_perr", int'(vperr1), 0);
    check("par_ok_ferr", int'(vferr1), 0);
    check("par_ok_lat", vtick1 - (st + 1), 168);
    c = vcnt1;
    send_frame(1, 8'h07, 1'b1, 1'b0, 1'b1, st);
    hold(1, 1'b1, 4);
    check("par_bad_cnt", vcnt1 - c, 1);
    check("par_bad_perr", int'(vperr1), 1);
    check("par_bad_perr_hold", int'(parity_err1), 1);

    // 0x3C with low stop bit, line then held low 40 more ticks.
    c = vcnt0;
    send_frame(0, 8'h3C, 1'b0, 1'b0, 1'b0, st);
    hold(0, 1'b0, 40);
    check("ferr_cnt", vcnt0 - c, 1);
    check("ferr_data", int'(vdata0), 8'h3C);
    check("ferr_flag", int'(vferr0), 1);
    check("ferr_hold", int'(frame_err0), 1);
    hold(0, 1'b1, 4);
    check("ferr_cnt_after", vcnt0 - c, 1);

    // Reset in the middle of data bit 3 of 0x5A (bits 0..3 = 0,1,0,1).
    c = vcnt0;
    hold(0, 1'b0, 16);
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 16);
    hold(0, 1'b0, 16);
    hold(0, 1'b1, 8);
    check("mid_busy_before", int'(rx_busy0), 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_reset_outputs("midrst");
    hold(0, 1'b1, 40);
    check("midrst_cnt", vcnt0 - c, 0);
    c = vcnt0;
    send_frame(0, 8'h5A, 1'b0, 1'b0, 1'b1, st);
    hold(0, 1'b1, 4);
    check("post_rst_cnt", vcnt0 - c, 1);
    check("post_rst_data", int'(vdata0), 8'h5A);
    check("post_rst_lat", vtick0 - (st + 1), 152);

    // Break: line low for 200 ticks -> exactly one all-zero framing error.
    hold(0, 1'b0, 0);
    check("brk_pre_data", int'(rx_data0), 8'h5A);
    c = vcnt0;
    st = tick_count + 1;
    hold(0, 1'b0, 200);
    check("brk_cnt", vcnt0 - c, 1);
    check("brk_data", int'(vdata0), 0);
    check("brk_ferr", int'(vferr0), 1);
    check("brk_lat", vtick0 - (st + 1), 152);
    hold(0, 1'b1, 4);
    check("brk_cnt_after", vcnt0 - c, 1);
    check("brk_busy_after", int'(rx_busy0), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
